// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: control/status bundle between the scan sequencer and its user.
//   en, hold, dwell, mask : scan control into the sequencer
//   s0, s1, mux_rst       : drive the 4:1 channel multiplexer
//   ch, ch_valid, wrap    : current channel, settled flag, end-of-scan pulse
// The mask signal exists only when CH_MASK_EN is defined.
// Modports: master = controlling side, slave = mux_scan_ctrl.
interface mux_scan_ctrl_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               en;
    logic               hold;
    logic [DWELL_W-1:0] dwell;
`ifdef CH_MASK_EN
    logic [3:0]         mask;
`endif
    logic               s0;
    logic               s1;
    logic               mux_rst;
    logic [1:0]         ch;
    logic               ch_valid;
    logic               wrap;

`ifdef CH_MASK_EN
    modport master (output en, hold, dwell, mask,
                    input  s0, s1, mux_rst, ch, ch_valid, wrap);
    modport slave  (input  en, hold, dwell, mask,
                    output s0, s1, mux_rst, ch, ch_valid, wrap);
`else
    modport master (output en, hold, dwell,
                    input  s0, s1, mux_rst, ch, ch_valid, wrap);
    modport slave  (input  en, hold, dwell,
                    output s0, s1, mux_rst, ch, ch_valid, wrap);
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin scan sequencer for a 4:1, 3-bit channel mux.
// Holds each channel for 1 settle cycle plus max(dwell,1) valid cycles.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : mux_scan_ctrl_if.slave (en/hold/dwell[/mask] in; s0/s1/mux_rst/ch/ch_valid/wrap out)
// Optional feature: define CH_MASK_EN to enable the per-channel skip mask.
// All outputs come straight from flops.
module mux_scan_ctrl #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_e;

    state_e             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic               mux_rst_q, mux_rst_d;
    logic               ch_valid_q, ch_valid_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_len_q, dwell_len_d;

    logic [3:0]         skip;
    logic [2:0]         first_pick;
    logic [2:0]         next_pick;

    // Returns {found, index} of the first unskipped channel after cur,
    // searching cyclically and ending with cur itself.
    function automatic logic [2:0] pick_next(input logic [1:0] cur, input logic [3:0] skp);
        logic [2:0] r;
        logic [1:0] c;
        r = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            c = cur + 2'(i);
            if (!r[2] && !skp[c]) r = {1'b1, c};
        end
        return r;
    endfunction

`ifdef CH_MASK_EN
    assign skip = bus.mask;
`else
    assign skip = '0;
`endif

    // Starting the search after channel 3 yields the lowest enabled channel.
    assign first_pick = pick_next(2'd3, skip);
    assign next_pick  = pick_next(ch_q, skip);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        mux_rst_d   = mux_rst_q;
        ch_valid_d  = ch_valid_q;
        wrap_d      = 1'b0;
        cnt_d       = cnt_q;
        dwell_len_d = dwell_len_q;

        if (!bus.en) begin
            state_d    = IDLE;
            ch_d       = '0;
            mux_rst_d  = 1'b1;
            ch_valid_d = 1'b0;
            cnt_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ch_d       = '0;
                    mux_rst_d  = 1'b1;
                    ch_valid_d = 1'b0;
                    if (first_pick[2]) begin
                        state_d   = SETTLE;
                        ch_d      = first_pick[1:0];
                        mux_rst_d = 1'b0;
                    end
                end
                SETTLE: begin
                    dwell_len_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                    cnt_d       = '0;
                    ch_valid_d  = 1'b1;
                    state_d     = DWELL;
                end
                DWELL: begin
                    if (!bus.hold) begin
                        if (cnt_q == dwell_len_q - DWELL_W'(1)) begin
                            cnt_d      = '0;
                            ch_valid_d = 1'b0;
                            if (next_pick[2]) begin
                                state_d = SETTLE;
                                ch_d    = next_pick[1:0];
                                wrap_d  = (next_pick[1:0] <= ch_q);
                            end else begin
                                // Every channel masked: fall back to idle.
                                state_d   = IDLE;
                                ch_d      = '0;
                                mux_rst_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + DWELL_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    ch_d       = '0;
                    mux_rst_d  = 1'b1;
                    ch_valid_d = 1'b0;
                    cnt_d      = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            mux_rst_q   <= 1'b1;
            ch_valid_q  <= 1'b0;
            wrap_q      <= 1'b0;
            cnt_q       <= '0;
            dwell_len_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            mux_rst_q   <= mux_rst_d;
            ch_valid_q  <= ch_valid_d;
            wrap_q      <= wrap_d;
            cnt_q       <= cnt_d;
            dwell_len_q <= dwell_len_d;
        end
    end

    assign bus.s0       = ch_q[0];
    assign bus.s1       = ch_q[1];
    assign bus.ch       = ch_q;
    assign bus.mux_rst  = mux_rst_q;
    assign bus.ch_valid = ch_valid_q;
    assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: self-checking bench for mux_scan_ctrl.
// A behavioural model tracks whether the scan is active, whether the current
// channel is in its settle cycle, and how many valid cycles it has left.
// Directed scenarios plus a randomized run; build with CH_MASK_EN to cover the mask.
module tb_mux_scan_ctrl;
    localparam int unsigned DWELL_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus ();
    mux_scan_ctrl #(.DWELL_W(DWELL_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model
    bit m_active = 1'b0;
    bit m_settle = 1'b0;
    bit m_wrap   = 1'b0;
    int m_ch     = 0;
    int m_left   = 0;

    // Wrap spacing measurement
    int cyc_count = 0;
    int last_wrap = -1;
    int exp_gap   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] cur_skip();
`ifdef CH_MASK_EN
        return bus.mask;
`else
        return 4'b0000;
`endif
    endfunction

    function automatic int lowest_enabled(input logic [3:0] skp);
        for (int k = 0; k < 4; k++) if (!skp[k]) return k;
        return -1;
    endfunction

    function automatic int following_enabled(input int cur, input logic [3:0] skp);
        for (int k = 1; k <= 4; k++) if (!skp[(cur + k) % 4]) return (cur + k) % 4;
        return -1;
    endfunction

    task automatic model_step();
        logic [3:0] skp;
        int n;
        skp    = cur_skip();
        m_wrap = 1'b0;
        if (!rst_n || !bus.en) begin
            m_active = 1'b0;
            m_settle = 1'b0;
            m_ch     = 0;
        end else if (!m_active) begin
            n = lowest_enabled(skp);
            if (n >= 0) begin
                m_active = 1'b1;
                m_settle = 1'b1;
                m_ch     = n;
            end
        end else if (m_settle) begin
            m_settle = 1'b0;
            m_left   = (bus.dwell == 0) ? 1 : int'(bus.dwell);
        end else if (!bus.hold) begin
            m_left--;
            if (m_left == 0) begin
                n = following_enabled(m_ch, skp);
                if (n < 0) begin
                    m_active = 1'b0;
                    m_ch     = 0;
                end else begin
                    m_wrap   = (n <= m_ch);
                    m_ch     = n;
                    m_settle = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cyc_count++;
        check("ch",       bus.ch,       m_ch);
        check("s0",       bus.s0,       m_ch % 2);
        check("s1",       bus.s1,       m_ch / 2);
        check("mux_rst",  bus.mux_rst,  !m_active);
        check("ch_valid", bus.ch_valid, m_active && !m_settle);
        check("wrap",     bus.wrap,     m_wrap);
        if (bus.wrap) begin
            if (exp_gap != 0 && last_wrap >= 0) check("wrap_gap", cyc_count - last_wrap, exp_gap);
            last_wrap = cyc_count;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) cyc();
        rst_n     = 1'b1;
        last_wrap = -1;
    endtask

    initial begin
        int run;
        bit found;
        rst_n     = 1'b0;
        bus.en    = 1'b1;
        bus.hold  = 1'b0;
        bus.dwell = 8'd3;
`ifdef CH_MASK_EN
        bus.mask  = 4'b0000;
`endif

        // Reset with en high, then full scan with dwell=3
        do_reset(2);
        exp_gap = 16;
        for (int i = 0; i < 50; i++) cyc();

        // dwell=0 behaves as 1
        bus.dwell = 8'd0;
        do_reset(1);
        exp_gap = 8;
        for (int i = 0; i < 30; i++) cyc();
        exp_gap = 0;

        // Hold for 5 cycles in the first valid cycle of ch1
        bus.dwell = 8'd3;
        do_reset(1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            found = (bus.ch == 2'd1) && bus.ch_valid;
        end
        check("hold_find", found, 1'b1);
        run = 1;
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (bus.ch == 2'd1 && bus.ch_valid) run++;
        end
        bus.hold = 1'b0;
        for (int i = 0; i < 20 && bus.ch == 2'd1 && bus.ch_valid; i++) begin
            cyc();
            if (bus.ch == 2'd1 && bus.ch_valid) run++;
        end
        check("hold_run", run, 8);
        check("hold_next_ch", bus.ch, 2);

        // Drop en while dwelling on ch2, then restart
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            found = (bus.ch == 2'd2) && bus.ch_valid;
        end
        check("en_find", found, 1'b1);
        bus.en = 1'b0;
        cyc();
        check("en_off_ch", bus.ch, 0);
        check("en_off_rst", bus.mux_rst, 1);
        check("en_off_valid", bus.ch_valid, 0);
        bus.en = 1'b1;
        cyc();
        check("en_on_ch", bus.ch, 0);
        check("en_on_rst", bus.mux_rst, 0);
        for (int i = 0; i < 10; i++) cyc();

`ifdef CH_MASK_EN
        // Skip channels 1 and 3, then mask everything
        bus.mask  = 4'b1010;
        bus.dwell = 8'd2;
        do_reset(1);
        exp_gap = 6;
        for (int i = 0; i < 30; i++) cyc();
        exp_gap = 0;
        bus.mask = 4'hF;
        for (int i = 0; i < 8; i++) cyc();
        check("mask_all_idle", bus.mux_rst, 1);
        bus.mask = 4'b0000;
`endif

        // Randomized run
        for (int i = 0; i < 1500; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            bus.en   = ($urandom_range(0, 39) != 0);
            bus.hold = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) bus.dwell = 8'($urandom_range(0, 5));
`ifdef CH_MASK_EN
            if ($urandom_range(0, 19) == 0) bus.mask = 4'($urandom_range(0, 15));
`endif
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
